// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: hazard FSM state and
// writeback-source encodings used by hazard_ctrl and forward_unit.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALTED   = 2'b10
  } hzstate_t;

  localparam logic [1:0] REGSRC_ALU  = 2'b00;
  localparam logic [1:0] REGSRC_NPC  = 2'b01;
  localparam logic [1:0] REGSRC_LUI  = 2'b10;
  localparam logic [1:0] REGSRC_DMEM = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC/latch enables and flushes for dmem wait,
// icache miss, load-use, control redirects and halt, plus counters and watchdog.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_me,
  input  logic             dmemWEN_me,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             rt_used_de,
  input  logic [4:0]       regDst_ex,
  input  logic             regWr_ex,
  input  logic [1:0]       regSrc_ex,
  input  logic             branch_taken_ex,
  input  logic             jump_de,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_ex,
  output logic             en_me,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  hzstate_t      state;
  logic [WW-1:0] wait_cnt;
  logic          halt_st;
  logic          mem_stall;
  logic          ld_haz;
  logic          redirect;
  logic          stall_inc;

  // Encoding 11 is never entered but must still freeze the pipe.
  assign halt_st   = state[1];
  assign state_o   = state;
  assign mem_stall = (dmemREN_me | dmemWEN_me) & ~dhit;
  assign ld_haz    = regWr_ex && (regSrc_ex == REGSRC_DMEM) && (regDst_ex != 5'd0) &&
                     ((regDst_ex == rs_de) || (rt_used_de && (regDst_ex == rt_de)));

  always_comb begin
    pc_en    = 1'b0;
    en_fd    = 1'b0;
    en_de    = 1'b0;
    en_ex    = 1'b0;
    en_me    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    halted   = 1'b0;
    redirect = 1'b0;
    if (halt_st || halt_wb) begin
      halted = 1'b1;
    end else if (mem_stall) begin
      pc_en = 1'b0;
    end else if (ld_haz) begin
      // Hold fetch/decode, push a bubble into EX so the load reaches MEM.
      en_de    = 1'b1;
      flush_de = 1'b1;
      en_ex    = 1'b1;
      en_me    = 1'b1;
    end else if (branch_taken_ex) begin
      {pc_en, en_fd, en_de, en_ex, en_me} = '1;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      redirect = 1'b1;
    end else if (jump_de) begin
      {pc_en, en_fd, en_de, en_ex, en_me} = '1;
      flush_fd = 1'b1;
      redirect = 1'b1;
    end else if (!ihit) begin
      {en_fd, en_de, en_ex, en_me} = '1;
      flush_fd = 1'b1;
    end else begin
      {pc_en, en_fd, en_de, en_ex, en_me} = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_wb)        state <= HALTED;
          else if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (halt_wb)   state <= HALTED;
          else if (dhit) state <= RUN;
        end
        default: state <= HALTED;
      endcase

      if ((state == MEM_WAIT) && !dhit) begin
        if (wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
        else                       mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign stall_inc = ~pc_en & ~halt_st & ~halt_wb;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (redirect),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle control vectors plus
// hand-written multi-cycle sequences (dmem wait, watchdog, halt, reset).
module tb_hazard_ctrl;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  localparam logic [7:0] RUN_ALL = 8'b1111_1000;
  localparam logic [7:0] LD      = 8'b0011_1010;
  localparam logic [7:0] BR      = 8'b1111_1110;
  localparam logic [7:0] JMP     = 8'b1111_1100;
  localparam logic [7:0] MISS    = 8'b0111_1100;
  localparam logic [7:0] FROZEN  = 8'b0000_0000;
  localparam logic [7:0] HALT    = 8'b0000_0001;

  localparam logic [1:0] ALU  = 2'b00;
  localparam logic [1:0] LUI  = 2'b10;
  localparam logic [1:0] DMEM = 2'b11;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       ren;
    logic       wen;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_used;
    logic [4:0] dst;
    logic       wr;
    logic [1:0] src;
    logic       br;
    logic       jmp;
    logic       halt;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, dmemREN_me, dmemWEN_me, rt_used_de, regWr_ex;
  logic branch_taken_ex, jump_de, halt_wb;
  logic [4:0] rs_de, rt_de, regDst_ex;
  logic [1:0] regSrc_ex;
  logic pc_en, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [1:0] state_o;

  wire [7:0] out_vec = {pc_en, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, halted};

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  vec_t vecs[17];

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .ihit            (ihit),
    .dhit            (dhit),
    .dmemREN_me      (dmemREN_me),
    .dmemWEN_me      (dmemWEN_me),
    .rs_de           (rs_de),
    .rt_de           (rt_de),
    .rt_used_de      (rt_used_de),
    .regDst_ex       (regDst_ex),
    .regWr_ex        (regWr_ex),
    .regSrc_ex       (regSrc_ex),
    .branch_taken_ex (branch_taken_ex),
    .jump_de         (jump_de),
    .halt_wb         (halt_wb),
    .pc_en           (pc_en),
    .en_fd           (en_fd),
    .en_de           (en_de),
    .en_ex           (en_ex),
    .en_me           (en_me),
    .flush_fd        (flush_fd),
    .flush_de        (flush_de),
    .halted          (halted),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  function automatic in_t mk(input logic ih, dh, rn, wn, input logic [4:0] rs, rt,
                             input logic ru, input logic [4:0] dst, input logic wr,
                             input logic [1:0] src, input logic br, jp, hl);
    in_t v;
    v = '{ih, dh, rn, wn, rs, rt, ru, dst, wr, src, br, jp, hl};
    return v;
  endfunction

  task automatic set_in(input in_t v);
    ihit = v.ihit; dhit = v.dhit; dmemREN_me = v.ren; dmemWEN_me = v.wen;
    rs_de = v.rs; rt_de = v.rt; rt_used_de = v.rt_used;
    regDst_ex = v.dst; regWr_ex = v.wr; regSrc_ex = v.src;
    branch_taken_ex = v.br; jump_de = v.jmp; halt_wb = v.halt;
  endtask

  task automatic idle_in();
    set_in(mk(1, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU, 0, 0, 0));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= (1 << CNT_W) - 1) ? c : c + 1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string name);
    @(negedge CLK);
    chk({name, " stall_cnt"}, 32'(stall_cnt), exp_stall);
    chk({name, " flush_cnt"}, 32'(flush_cnt), exp_flush);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{mk(1, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  0, 0, 0), RUN_ALL};
    vecs[1]  = '{mk(1, 0, 0, 0, 5'd5, 5'd2, 1, 5'd5, 1, DMEM, 0, 0, 0), LD};
    vecs[2]  = '{mk(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 1, DMEM, 0, 0, 0), RUN_ALL};
    vecs[3]  = '{mk(1, 0, 0, 0, 5'd1, 5'd5, 1, 5'd5, 1, DMEM, 0, 0, 0), LD};
    vecs[4]  = '{mk(1, 0, 0, 0, 5'd1, 5'd5, 0, 5'd5, 1, DMEM, 0, 0, 0), RUN_ALL};
    vecs[5]  = '{mk(1, 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, ALU,  0, 0, 0), RUN_ALL};
    vecs[6]  = '{mk(1, 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 0, DMEM, 0, 0, 0), RUN_ALL};
    vecs[7]  = '{mk(1, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  1, 0, 0), BR};
    vecs[8]  = '{mk(1, 0, 0, 0, 5'd5, 5'd2, 1, 5'd5, 1, DMEM, 1, 0, 0), LD};
    vecs[9]  = '{mk(1, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  1, 1, 0), BR};
    vecs[10] = '{mk(1, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  0, 1, 0), JMP};
    vecs[11] = '{mk(0, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  0, 0, 0), MISS};
    vecs[12] = '{mk(0, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  0, 1, 0), JMP};
    vecs[13] = '{mk(0, 0, 0, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  1, 0, 0), BR};
    vecs[14] = '{mk(1, 1, 1, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU,  0, 0, 0), RUN_ALL};
    vecs[15] = '{mk(0, 0, 0, 0, 5'd5, 5'd2, 1, 5'd5, 1, DMEM, 0, 0, 0), LD};
    vecs[16] = '{mk(1, 0, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, LUI,  0, 0, 0), RUN_ALL};

    nRST = 1'b0;
    idle_in();
    step();
    step();
    nRST = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("reset state_o", 32'(state_o), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset mem_timeout", 32'(mem_timeout), 32'd0);
    chk("reset outputs", 32'(out_vec), 32'(RUN_ALL));
    step();

    // Single-cycle control vectors
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].in);
      @(negedge CLK);
      chk($sformatf("vec%0d outputs", i), 32'(out_vec), 32'(vecs[i].exp));
      chk($sformatf("vec%0d state_o", i), 32'(state_o), 32'd0);
      if (!vecs[i].exp[7] && !vecs[i].exp[0]) exp_stall = sat_inc(exp_stall);
      if (vecs[i].exp == BR || vecs[i].exp == JMP) exp_flush = sat_inc(exp_flush);
      step();
    end
    idle_in();
    chk_counters("after table");
    step();

    // Load-use stall wins over a taken branch, branch redirects next cycle
    set_in(mk(1, 0, 0, 0, 5'd5, 5'd2, 1, 5'd5, 1, DMEM, 1, 0, 0));
    @(negedge CLK);
    chk("ld+br first cycle", 32'(out_vec), 32'(LD));
    exp_stall = sat_inc(exp_stall);
    step();
    set_in(mk(1, 0, 0, 0, 5'd5, 5'd2, 1, 5'd0, 0, ALU, 1, 0, 0));
    @(negedge CLK);
    chk("ld+br second cycle", 32'(out_vec), 32'(BR));
    exp_flush = sat_inc(exp_flush);
    step();
    idle_in();
    chk_counters("after ld+br");

    // Dmem wait: three frozen cycles then the completing hit
    do_reset();
    set_in(mk(1, 0, 1, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("dwait%0d outputs", k), 32'(out_vec), 32'(FROZEN));
      chk($sformatf("dwait%0d state_o", k), 32'(state_o), (k == 0) ? 32'd0 : 32'd1);
      exp_stall = sat_inc(exp_stall);
      step();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("dwait hit outputs", 32'(out_vec), 32'(BR));
    chk("dwait hit state_o", 32'(state_o), 32'd1);
    exp_flush = sat_inc(exp_flush);
    step();
    idle_in();
    @(negedge CLK);
    chk("dwait after hit state_o", 32'(state_o), 32'd0);
    chk_counters("after dwait");

    // Watchdog with MAX_WAIT=4: sets at the end of the 4th MEM_WAIT cycle
    step();
    do_reset();
    set_in(mk(1, 0, 0, 1, 5'd1, 5'd2, 1, 5'd3, 1, ALU, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_stall = sat_inc(exp_stall);
      @(negedge CLK);
      chk($sformatf("watchdog edge%0d", k), 32'(mem_timeout), (k == 5) ? 32'd1 : 32'd0);
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("watchdog hit outputs", 32'(out_vec), 32'(RUN_ALL));
    step();
    idle_in();
    @(negedge CLK);
    chk("watchdog sticky", 32'(mem_timeout), 32'd1);
    chk("watchdog state_o", 32'(state_o), 32'd0);
    chk_counters("after watchdog");

    // Stall counter saturation
    step();
    ihit = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      exp_stall = sat_inc(exp_stall);
    end
    idle_in();
    chk_counters("saturation");
    chk("saturation all-ones", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

    // Halt during a pending access, then inputs toggling while halted
    step();
    set_in(mk(1, 0, 1, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU, 0, 1, 1));
    @(negedge CLK);
    chk("halt_wb outputs", 32'(out_vec), 32'(HALT));
    step();
    for (int k = 0; k < 6; k++) begin
      set_in(mk(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
                1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0));
      @(negedge CLK);
      chk($sformatf("halted%0d outputs", k), 32'(out_vec), 32'(HALT));
      chk($sformatf("halted%0d state_o", k), 32'(state_o), 32'd2);
      step();
    end
    idle_in();
    chk_counters("while halted");

    // One reset edge leaves HALTED and clears everything
    do_reset();
    @(negedge CLK);
    chk("post-halt reset state_o", 32'(state_o), 32'd0);
    chk("post-halt reset mem_timeout", 32'(mem_timeout), 32'd0);
    chk("post-halt reset outputs", 32'(out_vec), 32'(RUN_ALL));
    chk_counters("post-halt reset");

    // Reset in the middle of a dmem wait
    step();
    set_in(mk(1, 0, 1, 0, 5'd1, 5'd2, 1, 5'd3, 1, ALU, 0, 0, 0));
    step();
    step();
    @(negedge CLK);
    chk("mid-wait state_o", 32'(state_o), 32'd1);
    chk("mid-wait stall_cnt", 32'(stall_cnt), 32'd2);
    do_reset();
    idle_in();
    @(negedge CLK);
    chk("mid-wait reset state_o", 32'(state_o), 32'd0);
    chk_counters("mid-wait reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
